// File: rtl/a2d_pkg.sv
// -----------------------------------------------------------------------------
// a2d_pkg
// Shared definitions for the ADC128S round-robin conversion scheduler:
//   - channel addresses of the four converted inputs (CH_LFT .. CH_BATT)
//   - scheduler state encoding (a2d_state_t)
//   - a2d_cmd()   : builds the 16-bit SPI command word for a channel
//   - a2d_chnl()  : maps the 2-bit round position to its channel address
// -----------------------------------------------------------------------------
package a2d_pkg;

   localparam logic [2:0] CH_LFT   = 3'd0;
   localparam logic [2:0] CH_RGHT  = 3'd4;
   localparam logic [2:0] CH_STEER = 3'd5;
   localparam logic [2:0] CH_BATT  = 3'd6;

   // Round position of the last channel; reaching it ends the round.
   localparam logic [1:0] IDX_LAST = 2'd3;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_SEL  = 4'd1,
      ST_WSEL = 4'd2,
      ST_GAP1 = 4'd3,
      ST_RD   = 4'd4,
      ST_WRD  = 4'd5,
      ST_CAP  = 4'd6,
      ST_GAP2 = 4'd7,
      ST_DONE = 4'd8
   } a2d_state_t;

   // Command word: {2'b00, channel, 11'h000}. The same word is sent for the
   // channel-select and the data-read transaction.
   function automatic logic [15:0] a2d_cmd(input logic [2:0] chnl);
      return {2'b00, chnl, 11'h000};
   endfunction

   // Round position -> channel address (lft, rght, steer, batt).
   function automatic logic [2:0] a2d_chnl(input logic [1:0] idx);
      logic [2:0] addr;
      case (idx)
         2'd0:    addr = CH_LFT;
         2'd1:    addr = CH_RGHT;
         2'd2:    addr = CH_STEER;
         2'd3:    addr = CH_BATT;
         default: addr = CH_LFT;
      endcase
      return addr;
   endfunction

endpackage

// File: rtl/a2d_round_sched.sv
// -----------------------------------------------------------------------------
// a2d_round_sched
// Round-robin conversion scheduler for the ADC128S front end. Each accepted
// `nxt` runs one round over the shared SPI master: lft, rght, steer, batt.
// Every conversion is a select transaction followed by a read transaction;
// the 12-bit read result lands in the channel's result register.
//
// Parameters:
//   GAP_CYC    idle cycles between any spi_done and the next spi_snd (1..15)
//   BATT_THRES battery-low threshold (only with A2D_BATT_LOW_EN)
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   nxt               start a round (accepted only when idle)
//   spi_snd, spi_cmd  transaction request pulse and its command word
//   spi_done,spi_resp transaction complete pulse and its read data
//   lft_ld, rght_ld, steer_pot, batt   latest conversion results
//   vld               one-cycle pulse when a round completes
//   busy              round in progress (cycle after nxt .. vld cycle)
//   batt_low          battery below BATT_THRES (only with A2D_BATT_LOW_EN)
//
// Build option: define A2D_BATT_LOW_EN to add the battery-low comparator and
// the batt_low port.
// -----------------------------------------------------------------------------
module a2d_round_sched
   import a2d_pkg::*;
#(
   parameter int unsigned GAP_CYC    = 1,
   parameter logic [11:0] BATT_THRES = 12'h800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        nxt,
   output logic        spi_snd,
   output logic [15:0] spi_cmd,
   input  logic        spi_done,
   input  logic [15:0] spi_resp,
   output logic [11:0] lft_ld,
   output logic [11:0] rght_ld,
   output logic [11:0] steer_pot,
   output logic [11:0] batt,
   output logic        vld,
   output logic        busy
`ifdef A2D_BATT_LOW_EN
   ,
   output logic        batt_low
`endif
);

   // Gap counter reload: the cycle that leaves WSEL/WRD counts as the first
   // gap cycle, so the counter starts at GAP_CYC-1 and expires on zero.
   localparam logic [3:0] GAP_LD = 4'(GAP_CYC - 1);

   a2d_state_t  state_r;
   logic [3:0]  gap_cnt_r;
   logic [1:0]  ch_idx_r;
   logic [1:0]  ch_nxt_s;
   logic        spi_snd_r;
   logic [15:0] spi_cmd_r;
   logic [11:0] lft_ld_r;
   logic [11:0] rght_ld_r;
   logic [11:0] steer_pot_r;
   logic [11:0] batt_r;
   logic        vld_r;
   logic        busy_r;

   // Upper response bits carry no conversion data.
   logic [3:0]  unused_resp_hi_s;
   assign unused_resp_hi_s = spi_resp[15:12];

`ifdef A2D_BATT_LOW_EN
   logic        batt_low_r;
   logic        batt_low_s;
   assign batt_low_s = (spi_resp[11:0] < BATT_THRES);
`else
   // Without the battery-low option the threshold has no consumer.
   logic [11:0] unused_batt_thres_s;
   assign unused_batt_thres_s = BATT_THRES;
`endif

   assign ch_nxt_s = ch_idx_r + 2'd1;

   // Round sequencer: state, gap counter, channel index and all outputs.
   // The result register is written on the edge that enters CAP because
   // spi_resp is only valid alongside spi_done; it is visible during CAP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         gap_cnt_r   <= 4'd0;
         ch_idx_r    <= 2'd0;
         spi_snd_r   <= 1'b0;
         spi_cmd_r   <= 16'h0000;
         lft_ld_r    <= 12'h000;
         rght_ld_r   <= 12'h000;
         steer_pot_r <= 12'h000;
         batt_r      <= 12'h000;
         vld_r       <= 1'b0;
         busy_r      <= 1'b0;
`ifdef A2D_BATT_LOW_EN
         batt_low_r  <= 1'b0;
`endif
      end else begin
         // Pulses default low; only the issuing transition raises them.
         spi_snd_r <= 1'b0;
         vld_r     <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (nxt) begin
                  state_r   <= ST_SEL;
                  spi_snd_r <= 1'b1;
                  spi_cmd_r <= a2d_cmd(a2d_chnl(ch_idx_r));
                  busy_r    <= 1'b1;
               end
            end
            ST_SEL: begin
               state_r <= ST_WSEL;
            end
            ST_WSEL: begin
               if (spi_done) begin
                  state_r   <= ST_GAP1;
                  gap_cnt_r <= GAP_LD;
               end
            end
            ST_GAP1: begin
               if (gap_cnt_r == 4'd0) begin
                  // Read repeats the select command still held in spi_cmd_r.
                  state_r   <= ST_RD;
                  spi_snd_r <= 1'b1;
               end else begin
                  gap_cnt_r <= gap_cnt_r - 4'd1;
               end
            end
            ST_RD: begin
               state_r <= ST_WRD;
            end
            ST_WRD: begin
               if (spi_done) begin
                  state_r   <= ST_CAP;
                  gap_cnt_r <= GAP_LD;
                  case (ch_idx_r)
                     2'd0:    lft_ld_r    <= spi_resp[11:0];
                     2'd1:    rght_ld_r   <= spi_resp[11:0];
                     2'd2:    steer_pot_r <= spi_resp[11:0];
                     2'd3:    batt_r      <= spi_resp[11:0];
                     default: lft_ld_r    <= lft_ld_r;
                  endcase
`ifdef A2D_BATT_LOW_EN
                  if (ch_idx_r == IDX_LAST) begin
                     batt_low_r <= batt_low_s;
                  end
`endif
               end
            end
            ST_CAP: begin
               // Index wraps back to lft after batt, ready for next round.
               ch_idx_r <= ch_nxt_s;
               if (ch_idx_r == IDX_LAST) begin
                  state_r <= ST_DONE;
                  vld_r   <= 1'b1;
               end else if (gap_cnt_r == 4'd0) begin
                  state_r   <= ST_SEL;
                  spi_snd_r <= 1'b1;
                  spi_cmd_r <= a2d_cmd(a2d_chnl(ch_nxt_s));
               end else begin
                  state_r   <= ST_GAP2;
                  gap_cnt_r <= gap_cnt_r - 4'd1;
               end
            end
            ST_GAP2: begin
               if (gap_cnt_r == 4'd0) begin
                  state_r   <= ST_SEL;
                  spi_snd_r <= 1'b1;
                  spi_cmd_r <= a2d_cmd(a2d_chnl(ch_idx_r));
               end else begin
                  gap_cnt_r <= gap_cnt_r - 4'd1;
               end
            end
            ST_DONE: begin
               // busy covers the vld cycle, then drops.
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r  <= ST_IDLE;
               ch_idx_r <= 2'd0;
               busy_r   <= 1'b0;
            end
         endcase
      end
   end

   assign spi_snd   = spi_snd_r;
   assign spi_cmd   = spi_cmd_r;
   assign lft_ld    = lft_ld_r;
   assign rght_ld   = rght_ld_r;
   assign steer_pot = steer_pot_r;
   assign batt      = batt_r;
   assign vld       = vld_r;
   assign busy      = busy_r;
`ifdef A2D_BATT_LOW_EN
   assign batt_low  = batt_low_r;
`endif

endmodule

// File: tb/tb_a2d_round_sched.sv
// -----------------------------------------------------------------------------
// tb_a2d_round_sched
// Directed self-checking bench for a2d_round_sched (GAP_CYC = 3). A task-based
// SPI responder answers each spi_snd with spi_done 20 cycles later. Expected
// results, command words and cycle distances are hand-computed constants.
// With A2D_BATT_LOW_EN defined the battery-low rounds are also exercised.
// -----------------------------------------------------------------------------
module tb_a2d_round_sched;

   localparam int GAP     = 3;
   localparam int TXN_LEN = 20;
   // nxt in cycle 0 -> first snd at 1; each snd->done is TXN_LEN, each
   // done->snd is GAP+1; last done at M gives vld at M+2.
   localparam int RND_LAT = 1 + 8 * TXN_LEN + 7 * (GAP + 1) + 2;

   logic        clk;
   logic        rst;
   logic        nxt;
   logic        spi_snd;
   logic [15:0] spi_cmd;
   logic        spi_done;
   logic [15:0] spi_resp;
   logic [11:0] lft_ld;
   logic [11:0] rght_ld;
   logic [11:0] steer_pot;
   logic [11:0] batt;
   logic        vld;
   logic        busy;
`ifdef A2D_BATT_LOW_EN
   logic        batt_low;
`endif

   a2d_round_sched #(
      .GAP_CYC   (GAP),
      .BATT_THRES(12'h800)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .nxt      (nxt),
      .spi_snd  (spi_snd),
      .spi_cmd  (spi_cmd),
      .spi_done (spi_done),
      .spi_resp (spi_resp),
      .lft_ld   (lft_ld),
      .rght_ld  (rght_ld),
      .steer_pot(steer_pot),
      .batt     (batt),
      .vld      (vld),
      .busy     (busy)
`ifdef A2D_BATT_LOW_EN
      ,
      .batt_low (batt_low)
`endif
   );

   int checks_r = 0;
   int errors_r = 0;
   int cyc_r    = 0;
   int snd_cnt_r = 0;
   int vld_cnt_r = 0;
   int dbl_cnt_r = 0;
   logic prev_snd_r = 1'b0;
   int last_done;

   logic [15:0] cmd_tbl [4] = '{16'h0000, 16'h2000, 16'h2800, 16'h3000};
   logic [11:0] mdl [4];
   logic        mdl_low;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle count and event counters sampled at each active edge.
   always @(posedge clk) begin
      cyc_r      <= cyc_r + 1;
      prev_snd_r <= spi_snd;
      if (spi_snd) snd_cnt_r <= snd_cnt_r + 1;
      if (vld) vld_cnt_r <= vld_cnt_r + 1;
      if (spi_snd && prev_snd_r) dbl_cnt_r <= dbl_cnt_r + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_r++;
      if (got !== exp) begin
         errors_r++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] res_of(input int ch);
      case (ch)
         0:       return lft_ld;
         1:       return rght_ld;
         2:       return steer_pot;
         default: return batt;
      endcase
   endfunction

   // Wait (bounded) until spi_snd is high in the current cycle.
   task automatic wait_snd();
      int n;
      n = 0;
      while (spi_snd !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      check_eq("snd_wait", (n < 200) ? 32'd1 : 32'd0, 32'd1);
   endtask

   // One SPI transaction: checks command and done->snd gap, answers with
   // spi_done TXN_LEN cycles after spi_snd. Returns in cycle done+1 (or
   // done+2 when a spurious done is injected after it).
   task automatic spi_txn(input logic [15:0] resp, input logic [15:0] exp_cmd,
                          input bit inj_nxt, input bit spur);
      wait_snd();
      if (last_done >= 0) check_eq("gap", cyc_r - last_done, GAP + 1);
      check_eq("cmd", {16'h0000, spi_cmd}, {16'h0000, exp_cmd});
      for (int k = 1; k < TXN_LEN; k++) begin
         step();
         nxt = (inj_nxt && k == 8) ? 1'b1 : 1'b0;
      end
      nxt = 1'b0;
      step();
      spi_done  = 1'b1;
      spi_resp  = resp;
      last_done = cyc_r;
      step();
      spi_done = 1'b0;
      spi_resp = 16'h0000;
      if (spur) begin
         spi_done = 1'b1;
         spi_resp = 16'hDEAD;
         step();
         spi_done = 1'b0;
         spi_resp = 16'h0000;
      end
   endtask

   task automatic run_round(input logic [15:0] r0, input logic [15:0] r1,
                            input logic [15:0] r2, input logic [15:0] r3,
                            input bit inj, input bit spur, input bit exp_low);
      logic [15:0] rsp [4];
      int t_nxt;
      int snd0;
      int vld0;
      rsp  = '{r0, r1, r2, r3};
      snd0 = snd_cnt_r;
      vld0 = vld_cnt_r;
      nxt   = 1'b1;
      t_nxt = cyc_r;
      step();
      nxt = 1'b0;
      check_eq("busy_start", {31'd0, busy}, 32'd1);
      last_done = -1;
      for (int ch = 0; ch < 4; ch++) begin
         spi_txn(16'hFFFF, cmd_tbl[ch], 1'b0, spur && ch == 0);
         check_eq("hold", {20'd0, res_of(ch)}, {20'd0, mdl[ch]});
`ifdef A2D_BATT_LOW_EN
         if (ch == 3) check_eq("low_hold", {31'd0, batt_low}, {31'd0, mdl_low});
`endif
         spi_txn(rsp[ch], cmd_tbl[ch], inj && ch == 1, 1'b0);
         mdl[ch] = rsp[ch][11:0];
         check_eq("result", {20'd0, res_of(ch)}, {20'd0, mdl[ch]});
      end
`ifdef A2D_BATT_LOW_EN
      mdl_low = exp_low;
      check_eq("batt_low", {31'd0, batt_low}, {31'd0, mdl_low});
`else
      mdl_low = exp_low;
`endif
      check_eq("vld_early", {31'd0, vld}, 32'd0);
      step();
      check_eq("vld", {31'd0, vld}, 32'd1);
      check_eq("busy_vld", {31'd0, busy}, 32'd1);
      check_eq("latency", cyc_r - t_nxt, RND_LAT);
      step();
      check_eq("busy_end", {31'd0, busy}, 32'd0);
      repeat (5) step();
      check_eq("snd_count", snd_cnt_r - snd0, 32'd8);
      check_eq("vld_count", vld_cnt_r - vld0, 32'd1);
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_snd"},  {31'd0, spi_snd}, 32'd0);
      check_eq({tag, "_cmd"},  {16'd0, spi_cmd}, 32'd0);
      check_eq({tag, "_vld"},  {31'd0, vld}, 32'd0);
      check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check_eq({tag, "_lft"},  {20'd0, lft_ld}, 32'd0);
      check_eq({tag, "_rght"}, {20'd0, rght_ld}, 32'd0);
      check_eq({tag, "_steer"},{20'd0, steer_pot}, 32'd0);
      check_eq({tag, "_batt"}, {20'd0, batt}, 32'd0);
`ifdef A2D_BATT_LOW_EN
      check_eq({tag, "_low"},  {31'd0, batt_low}, 32'd0);
`endif
   endtask

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int snd0;
      rst      = 1'b1;
      nxt      = 1'b0;
      spi_done = 1'b0;
      spi_resp = 16'h0000;
      mdl      = '{12'h000, 12'h000, 12'h000, 12'h000};
      mdl_low  = 1'b0;
      last_done = -1;

      // Reset state, during and after reset.
      repeat (2) step();
      check_zero("rst");
      rst = 1'b0;
      repeat (3) step();
      check_zero("post_rst");

      // Basic round: hand values 123, A55, 777, C00.
      run_round(16'hF123, 16'h0A55, 16'h0777, 16'h0C00, 1'b0, 1'b0, 1'b0);
      check_eq("lft_val",   {20'd0, lft_ld},    32'h123);
      check_eq("rght_val",  {20'd0, rght_ld},   32'hA55);
      check_eq("steer_val", {20'd0, steer_pot}, 32'h777);
      check_eq("batt_val",  {20'd0, batt},      32'hC00);

      // nxt during rght WRD and spurious done in GAP1: one round only.
      run_round(16'hF123, 16'h0A55, 16'h0777, 16'h0C00, 1'b1, 1'b1, 1'b0);
      check_eq("lft_keep",  {20'd0, lft_ld},    32'h123);
      check_eq("batt_keep", {20'd0, batt},      32'hC00);

      // Reset in the middle of the steer read.
      nxt = 1'b1;
      step();
      nxt = 1'b0;
      last_done = -1;
      spi_txn(16'hFFFF, 16'h0000, 1'b0, 1'b0);
      spi_txn(16'h0111, 16'h0000, 1'b0, 1'b0);
      spi_txn(16'hFFFF, 16'h2000, 1'b0, 1'b0);
      spi_txn(16'h0222, 16'h2000, 1'b0, 1'b0);
      spi_txn(16'hFFFF, 16'h2800, 1'b0, 1'b0);
      check_eq("pre_rst_lft", {20'd0, lft_ld}, 32'h111);
      wait_snd();
      repeat (5) step();
      #2;
      rst = 1'b1;
      #1;
      check_zero("abort");
      @(posedge clk);
      #1;
      check_zero("abort_hold");
      rst = 1'b0;
      mdl     = '{12'h000, 12'h000, 12'h000, 12'h000};
      mdl_low = 1'b0;
      snd0 = snd_cnt_r;
      spi_done = 1'b1;
      spi_resp = 16'h0333;
      step();
      spi_done = 1'b0;
      spi_resp = 16'h0000;
      repeat (30) step();
      check_eq("abort_no_snd", snd_cnt_r - snd0, 32'd0);
      check_eq("abort_steer",  {20'd0, steer_pot}, 32'd0);
      run_round(16'hF123, 16'h0A55, 16'h0777, 16'h0C00, 1'b0, 1'b0, 1'b0);

`ifdef A2D_BATT_LOW_EN
      // Threshold 800: 7FF is low, 800 is not.
      run_round(16'h0100, 16'h0200, 16'h0300, 16'h07FF, 1'b0, 1'b0, 1'b1);
      run_round(16'h0100, 16'h0200, 16'h0300, 16'h0800, 1'b0, 1'b0, 1'b0);
`endif

      check_eq("no_back_to_back_snd", dbl_cnt_r, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
      $finish;
   end

endmodule
